// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: unified memory port, FSM controller, 32x32 register file.
// Optional jal support is compiled in when the macro MCDP_JAL_EN is defined.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          HALT_ON_ILLEGAL = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

`ifdef MCDP_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif
  localparam bit HALT_EN = (HALT_ON_ILLEGAL != 0);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
  logic        retire_reg, retire_next;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sign_imm, alu_result;
  logic        funct_ok, illegal;

  logic [31:0] rf [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign opcode   = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign funct    = ir_reg[5:0];
  assign sign_imm = {{16{ir_reg[15]}}, ir_reg[15:0]};

  assign pc     = pc_reg;
  assign retire = retire_reg;
  assign halted = (state_reg == HALT);

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
    illegal = 1'b1;
    case (opcode)
      OP_RTYPE:                         illegal = !funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
      OP_JAL:                           illegal = !JAL_EN;
      default:                          illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_result = a_reg + b_reg;
    case (funct)
      FN_SUB:  alu_result = a_reg - b_reg;
      FN_AND:  alu_result = a_reg & b_reg;
      FN_OR:   alu_result = a_reg | b_reg;
      FN_SLT:  alu_result = {31'b0, ($signed(a_reg) < $signed(b_reg))};
      default: alu_result = a_reg + b_reg;
    endcase
  end

  // r0 has no storage, so writes to it vanish and reads return zero.
  assign rf[0] = '0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_rf
    logic [31:0] word_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_reg <= '0;
      end else if (rf_we && rf_waddr == 5'(gi)) begin
        word_reg <= rf_wdata;
      end
    end
    assign rf[gi] = word_reg;
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = mdr_reg;
    case (state_reg)
      MEMWB:  rf_we = 1'b1;
      ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        rf_wdata = alu_out_reg;
      end
      ADDIWB: begin
        rf_we    = 1'b1;
        rf_wdata = alu_out_reg;
      end
      JUMP: begin
        rf_we    = JAL_EN && (opcode == OP_JAL);
        rf_waddr = 5'd31;
        rf_wdata = pc_reg;
      end
      default: rf_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Memory-port outputs decode from registered state only; reset gates the request.
  always_comb begin
    state_next  = state_reg;
    retire_next = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = pc_reg;
    mem_wdata   = b_reg;
    case (state_reg)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        if (illegal) begin
          state_next  = HALT_EN ? HALT : FETCH;
          retire_next = !HALT_EN;
        end else begin
          case (opcode)
            OP_LW, OP_SW: state_next = MEMADR;
            OP_RTYPE:     state_next = EXEC;
            OP_BEQ:       state_next = BRANCH;
            OP_ADDI:      state_next = ADDIEX;
            default:      state_next = JUMP;
          endcase
        end
      end
      MEMADR: state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        mem_req  = 1'b1;
        mem_addr = alu_out_reg;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = alu_out_reg;
        if (mem_ready) begin
          state_next  = FETCH;
          retire_next = 1'b1;
        end
      end
      EXEC:   state_next = ALUWB;
      ADDIEX: state_next = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: begin
        state_next  = FETCH;
        retire_next = 1'b1;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
    if (reset) mem_req = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      alu_out_reg <= '0;
      mdr_reg     <= '0;
      retire_reg  <= 1'b0;
    end else begin
      retire_reg <= retire_next;
      case (state_reg)
        FETCH: begin
          if (mem_ready) begin
            ir_reg <= mem_rdata;
            pc_reg <= pc_reg + 32'd4;
          end
        end
        DECODE: begin
          a_reg       <= rf[rs];
          b_reg       <= rf[rt];
          alu_out_reg <= pc_reg + (sign_imm << 2);
        end
        MEMADR, ADDIEX: alu_out_reg <= a_reg + sign_imm;
        MEMRD: if (mem_ready) mdr_reg <= mem_rdata;
        EXEC:  alu_out_reg <= alu_result;
        BRANCH: if (a_reg == b_reg) pc_reg <= alu_out_reg;
        JUMP:  pc_reg <= {pc_reg[31:28], ir_reg[25:0], 2'b00};
        default: ;
      endcase
    end
  end

endmodule
